bsg_front_side_bus_hop_out: RTL and testbench
=============================================

BSG_FRONT_SIDE_BUS_HOP_OUT -- requirements
Module: bsg_front_side_bus_hop_out

Interface
REQ-001 Parameter width_p, default 16, flit width in bits.
REQ-002 Parameter inputs_p, default 2, number of requesters; legal range 2..8.
REQ-003 clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 v_i  input  inputs_p  per-requester valid.
REQ-006 data_i  input  inputs_p*width_p  per-requester flit; requester k occupies bits [k*width_p +: width_p].
REQ-007 ready_o  output  inputs_p  per-requester ready; a flit transfers when v_i[k] & ready_o[k].
REQ-008 v_o  output  1  output flit valid.
REQ-009 data_o  output  width_p  output flit.
REQ-010 ready_i  input  1  downstream ready; a flit transfers when v_o & ready_i.

Function
REQ-011 Each requester SHALL be buffered by its own two-element FIFO: bsg_two_fifo, width_p wide.
REQ-012 ready_o[k] SHALL equal "FIFO k not full"; it SHALL NOT depend on v_i, ready_i or grant state.
REQ-013 A flit accepted on cycle t SHALL be presentable on v_o no earlier than cycle t+1; no input-to-output combinational path.
REQ-014 Arbitration SHALL be round-robin over FIFO-valid bits, with priority starting at index (last_r+1) mod inputs_p.
REQ-015 last_r SHALL be log2(inputs_p) bits; it updates to the granted index only on an output transfer.
REQ-016 v_o SHALL be 1 whenever any FIFO is non-empty; data_o SHALL be the head of the granted FIFO.
REQ-017 Lock rule: once v_o=1 and ready_i=0, the grant SHALL be held (locked_r=1, grant_r=current index).
REQ-018 While locked, v_o and data_o SHALL remain stable, even if a higher-priority FIFO becomes valid.
REQ-019 locked_r SHALL clear on the transfer cycle; the next grant SHALL be recomputed that same cycle from updated last_r.
REQ-020 The granted FIFO SHALL see yumi only when v_o & ready_i; all other FIFOs SHALL see yumi=0.
REQ-021 Simultaneous enqueue and dequeue on one FIFO SHALL be handled by the FIFO; the arbiter adds no bubble.
REQ-022 Full throughput: with any requester continuously valid and ready_i=1, v_o SHALL be 1 every cycle.
REQ-023 Wrap-around: priority after index inputs_p-1 SHALL continue at index 0; non-power-of-2 inputs_p SHALL skip unused codes.
REQ-024 Fairness: a continuously valid requester SHALL be granted within inputs_p transfers.

Reset
REQ-025 While reset_i=1, v_o SHALL be 0 and ready_o SHALL be all-zero.
REQ-026 Reset SHALL set all FIFOs empty, locked_r=0, grant_r=0, and last_r=inputs_p-1, so requester 0 has first priority.
REQ-027 Reset asserted mid-lock SHALL discard all buffered flits; nothing is emitted after reset deasserts until new input arrives.
REQ-028 From the first cycle after reset_i=0, ready_o SHALL be all-ones.

Structure
REQ-029 No shared-package typedefs are needed; width_p and inputs_p are module parameters only.
REQ-030 Round-robin selection SHALL be a separate sub-module, bsg_round_robin_arb_hold.
REQ-031 bsg_round_robin_arb_hold inputs: reqs, hold, yumi; outputs: grant one-hot, grant index.
REQ-032 The FIFO SHALL reuse the existing bsg_two_fifo unchanged.
REQ-033 data_o SHALL be driven by a one-hot mux over FIFO heads.

Verification
REQ-034 Case A: reset; v_i=2'b11 for one cycle with data 0x1111 (req0) and 0x2222 (req1); ready_i=1 -> v_o=1 for exactly two cycles, emitting 0x1111 then 0x2222.
REQ-035 Case B: both requesters stream continuously, ready_i=1 -> grants alternate 0,1,0,1; v_o never drops.
REQ-036 Case C: FIFO1 holds 0xBEEF and is granted; ready_i=0 for 5 cycles while req0 becomes valid -> data_o stays 0xBEEF and v_o stays 1; on ready_i=1, 0xBEEF transfers and req0 goes next.
REQ-037 Case D: ready_i=0; push 3 flits to req0 -> ready_o[0]=0 after the 2nd acceptance; the 3rd is held off until the first output transfer.
REQ-038 Case E: inputs_p=3, only req2 valid -> every transfer grants req2; then assert all three -> order is 0,1,2 after last_r=2.
REQ-039 Case F: assert reset_i while locked with both FIFOs full -> v_o=0 the next cycle; no stale flit appears after reset deasserts.

Source files
------------

// File: rtl/bsg_front_side_bus_hop_out_pkg.sv
// Shared helpers for the front-side-bus hop-out arbiter slice.
// Latency: n/a (constant functions only).
// Backpressure: n/a.
package bsg_front_side_bus_hop_out_pkg;

  // Width of a requester index; never below 1 so two requesters still get a bit.
  function automatic int lg_idx(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Wrap a priority index back into 0..n-1. The caller never exceeds 2n-1,
  // so one subtraction is enough and unused codes of a non power-of-2 n are skipped.
  function automatic int rr_wrap(input int idx, input int n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

// File: rtl/bsg_round_robin_arb_hold.sv
// Round-robin arbiter that can freeze its grant while the consumer stalls.
// Latency: combinational grant from registered priority/lock state.
// Backpressure: i_hold locks the current grant until i_yumi reports the transfer.
module bsg_round_robin_arb_hold
  import bsg_front_side_bus_hop_out_pkg::*;
#(
  parameter int inputs_p = 2,
  parameter int lg_p     = lg_idx(inputs_p)
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [inputs_p-1:0] i_reqs,
  input  logic                i_hold,
  input  logic                i_yumi,
  output logic [inputs_p-1:0] o_grant,
  output logic [lg_p-1:0]     o_grant_idx
);

  logic [lg_p-1:0] r_last;
  logic [lg_p-1:0] r_grant_idx;
  logic            r_locked;
  logic [lg_p-1:0] w_rr_idx;
  logic            w_any;

  assign w_any       = |i_reqs;
  assign o_grant_idx = r_locked ? r_grant_idx : w_rr_idx;

  // Search from last+1 upward with wrap; scanning high offsets first lets the
  // nearest requester overwrite the choice, so the lowest offset wins.
  always_comb begin
    w_rr_idx = r_last;
    for (int i = inputs_p - 1; i >= 0; i--) begin
      if (i_reqs[rr_wrap(int'(r_last) + 1 + i, inputs_p)]) begin
        w_rr_idx = lg_p'(rr_wrap(int'(r_last) + 1 + i, inputs_p));
      end
    end
  end

  // One-hot view of the selected index; empty when nothing is requesting.
  always_comb begin
    o_grant = '0;
    if (r_locked || w_any) begin
      o_grant[o_grant_idx] = 1'b1;
    end
  end

  // Priority advances only on a real transfer; a stall pins the grant.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_last      <= lg_p'(inputs_p - 1);
      r_locked    <= 1'b0;
      r_grant_idx <= '0;
    end else if (i_yumi) begin
      r_last   <= o_grant_idx;
      r_locked <= 1'b0;
    end else if (i_hold) begin
      r_locked    <= 1'b1;
      r_grant_idx <= o_grant_idx;
    end
  end

endmodule

// File: rtl/bsg_two_fifo.sv
// Two-entry FIFO with valid/yumi dequeue.
// Latency: 1 cycle from enqueue to head valid; no input-to-output path.
// Backpressure: ready_o is "not full" only; enqueue and dequeue may coincide.
module bsg_two_fifo #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] r_mem [2];
  logic [1:0]         r_count;
  logic               r_wptr;
  logic               r_rptr;
  logic               w_enq;
  logic               w_deq;

  assign ready_o = (r_count != 2'd2);
  assign v_o     = (r_count != 2'd0);
  assign data_o  = r_mem[r_rptr];
  assign w_enq   = v_i & ready_o;
  assign w_deq   = yumi_i & v_o;

  // Occupancy and pointer bookkeeping; reset empties the FIFO.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= 2'd0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
    end else begin
      r_count <= r_count + {1'b0, w_enq} - {1'b0, w_deq};
      r_wptr  <= r_wptr ^ w_enq;
      r_rptr  <= r_rptr ^ w_deq;
    end
  end

  // Storage is written on enqueue only; contents are don't-care when empty.
  always_ff @(posedge clk_i) begin
    if (w_enq) begin
      r_mem[r_wptr] <= data_i;
    end
  end

endmodule

// File: rtl/bsg_front_side_bus_hop_out.sv
// N-to-1 hop-out: per-requester two-entry buffering, round-robin merge onto one link.
// Latency: 1 cycle minimum from input acceptance to output valid.
// Backpressure: ready_o is FIFO-not-full; a stalled output holds its grant and data stable.
module bsg_front_side_bus_hop_out
  import bsg_front_side_bus_hop_out_pkg::*;
#(
  parameter int width_p  = 16,
  parameter int inputs_p = 2
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic [inputs_p-1:0]         v_i,
  input  logic [inputs_p*width_p-1:0] data_i,
  output logic [inputs_p-1:0]         ready_o,
  output logic                        v_o,
  output logic [width_p-1:0]          data_o,
  input  logic                        ready_i
);

  localparam int lg_lp = lg_idx(inputs_p);

  logic [inputs_p-1:0] w_fifo_rdy;
  logic [inputs_p-1:0] w_fifo_v;
  logic [width_p-1:0]  w_fifo_dat [inputs_p];
  logic [inputs_p-1:0] w_grant;
  logic [inputs_p-1:0] w_yumi;
  logic [lg_lp-1:0]    w_grant_idx;
  logic                w_xfer;
  logic                w_hold;

  for (genvar k = 0; k < inputs_p; k++) begin : g_fifo
    bsg_two_fifo #(.width_p(width_p)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .ready_o (w_fifo_rdy[k]),
      .data_i  (data_i[k*width_p +: width_p]),
      .v_i     (v_i[k]),
      .v_o     (w_fifo_v[k]),
      .data_o  (w_fifo_dat[k]),
      .yumi_i  (w_yumi[k])
    );
  end

  // Reset masks the handshake outputs even before the FIFOs have cleared.
  assign ready_o = w_fifo_rdy & {inputs_p{~reset_i}};
  assign v_o     = (|w_fifo_v) & ~reset_i;
  assign w_xfer  = v_o & ready_i;
  assign w_hold  = v_o & ~ready_i;

  bsg_round_robin_arb_hold #(.inputs_p(inputs_p), .lg_p(lg_lp)) u_arb (
    .i_clk       (clk_i),
    .i_reset     (reset_i),
    .i_reqs      (w_fifo_v),
    .i_hold      (w_hold),
    .i_yumi      (w_xfer),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx)
  );

  // Only the granted FIFO is popped, and only when the link actually moves a flit.
  always_comb begin
    w_yumi = '0;
    for (int k = 0; k < inputs_p; k++) begin
      w_yumi[k] = w_xfer && (w_grant_idx == lg_lp'(k));
    end
  end

  // AND-OR mux over FIFO heads steered by the one-hot grant.
  always_comb begin
    data_o = '0;
    for (int k = 0; k < inputs_p; k++) begin
      if (w_grant[k]) begin
        data_o = data_o | w_fifo_dat[k];
      end
    end
  end

endmodule

// File: tb/tb_bsg_front_side_bus_hop_out.sv
module tb_bsg_front_side_bus_hop_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // two-requester instance
  logic        reset_i;
  logic [1:0]  v_i;
  logic [31:0] data_i;
  logic [1:0]  ready_o;
  logic        v_o;
  logic [15:0] data_o;
  logic        ready_i;

  // three-requester instance
  logic        rst3;
  logic [2:0]  v3;
  logic [47:0] d3;
  logic [2:0]  rdy3_o;
  logic        v3_o;
  logic [15:0] d3_o;
  logic        rdy3_i;

  bsg_front_side_bus_hop_out #(.width_p(16), .inputs_p(2)) u_dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
    .ready_o(ready_o), .v_o(v_o), .data_o(data_o), .ready_i(ready_i)
  );

  bsg_front_side_bus_hop_out #(.width_p(16), .inputs_p(3)) u_dut3 (
    .clk_i(clk), .reset_i(rst3), .v_i(v3), .data_i(d3),
    .ready_o(rdy3_o), .v_o(v3_o), .data_o(d3_o), .ready_i(rdy3_i)
  );

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_i = 1'b1; v_i = 2'b00; data_i = '0; ready_i = 1'b0;
    rst3 = 1'b1; v3 = 3'b000; d3 = '0; rdy3_i = 1'b0;
    cyc; cyc; cyc;
    v_i = 2'b11; data_i = 32'hDEAD_BEEF;
    #1;
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL rst_v_o got=%b want=0", v_o); end
    tests++; if (ready_o !== 2'b00) begin fails++; $display("FAIL rst_ready_o got=%b want=00", ready_o); end
    tests++; if (v3_o !== 1'b0) begin fails++; $display("FAIL rst3_v_o got=%b want=0", v3_o); end
    tests++; if (rdy3_o !== 3'b000) begin fails++; $display("FAIL rst3_ready_o got=%b want=000", rdy3_o); end
    cyc;
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL rst_v_o_with_vi got=%b want=0", v_o); end
    v_i = 2'b00;
    cyc;
    reset_i = 1'b0; rst3 = 1'b0;
    #1;
    tests++; if (ready_o !== 2'b11) begin fails++; $display("FAIL post_rst_ready_o got=%b want=11", ready_o); end
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL post_rst_v_o got=%b want=0", v_o); end
    tests++; if (rdy3_o !== 3'b111) begin fails++; $display("FAIL post_rst3_ready_o got=%b want=111", rdy3_o); end
  endtask

  task automatic test_case_a;
    cyc;
    v_i = 2'b11; data_i = {16'h2222, 16'h1111}; ready_i = 1'b1;
    #1;
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL a_no_comb_path v_o=%b want=0", v_o); end
    cyc;
    v_i = 2'b00;
    #1;
    tests++; if (v_o !== 1'b1 || data_o !== 16'h1111) begin fails++; $display("FAIL a_first v_o=%b data=%h want 1/1111", v_o, data_o); end
    cyc; #1;
    tests++; if (v_o !== 1'b1 || data_o !== 16'h2222) begin fails++; $display("FAIL a_second v_o=%b data=%h want 1/2222", v_o, data_o); end
    cyc; #1;
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL a_done v_o=%b want=0", v_o); end
  endtask

  // last=1 on entry, so req0 would win if the lock were not honoured
  task automatic test_case_c_lock;
    cyc;
    ready_i = 1'b0; v_i = 2'b10; data_i = {16'hBEEF, 16'h0000};
    #1;
    cyc;
    v_i = 2'b01; data_i = {16'h0000, 16'h1234};
    #1;
    tests++; if (v_o !== 1'b1 || data_o !== 16'hBEEF) begin fails++; $display("FAIL c_grant v_o=%b data=%h want 1/beef", v_o, data_o); end
    for (int k = 0; k < 5; k++) begin
      cyc;
      v_i = 2'b00;
      #1;
      tests++; if (v_o !== 1'b1 || data_o !== 16'hBEEF) begin fails++; $display("FAIL c_hold%0d v_o=%b data=%h want 1/beef", k, v_o, data_o); end
    end
    cyc;
    ready_i = 1'b1;
    #1;
    tests++; if (data_o !== 16'hBEEF) begin fails++; $display("FAIL c_release data=%h want beef", data_o); end
    cyc; #1;
    tests++; if (v_o !== 1'b1 || data_o !== 16'h1234) begin fails++; $display("FAIL c_next v_o=%b data=%h want 1/1234", v_o, data_o); end
    cyc; #1;
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL c_done v_o=%b want=0", v_o); end
  endtask

  // last=0 on entry, so req1 leads: B000 A000 B001 A001 ...
  task automatic test_back_to_back;
    int c0;
    int c1;
    logic [15:0] exp;
    bit done;
    c0 = 0; c1 = 0; done = 1'b0;
    ready_i = 1'b1;
    for (int j = 0; j < 9; j++) begin
      cyc;
      v_i = 2'b11;
      data_i = {16'(16'hB000 + c1), 16'(16'hA000 + c0)};
      #1;
      if (j >= 1) begin
        exp = (((j - 1) % 2) == 0) ? 16'(16'hB000 + (j - 1) / 2) : 16'(16'hA000 + (j - 1) / 2);
        tests++; if (v_o !== 1'b1 || data_o !== exp) begin fails++; $display("FAIL b_out%0d v_o=%b data=%h want 1/%h", j, v_o, data_o, exp); end
      end
      if (ready_o[0]) c0++;
      if (ready_o[1]) c1++;
    end
    for (int j = 0; j < 10 && !done; j++) begin
      cyc;
      v_i = 2'b00;
      #1;
      if (v_o === 1'b0) done = 1'b1;
    end
    tests++; if (!done) begin fails++; $display("FAIL b_drain timeout v_o=%b want=0", v_o); end
  endtask

  task automatic test_case_d_full;
    cyc;
    ready_i = 1'b0; v_i = 2'b01; data_i = {16'h0000, 16'hD001};
    #1;
    tests++; if (ready_o[0] !== 1'b1) begin fails++; $display("FAIL d_rdy_first got=%b want=1", ready_o[0]); end
    cyc;
    data_i = {16'h0000, 16'hD002};
    #1;
    tests++; if (ready_o[0] !== 1'b1) begin fails++; $display("FAIL d_rdy_second got=%b want=1", ready_o[0]); end
    cyc;
    data_i = {16'h0000, 16'hD003};
    #1;
    tests++; if (ready_o[0] !== 1'b0) begin fails++; $display("FAIL d_full got=%b want=0", ready_o[0]); end
    cyc; #1;
    tests++; if (ready_o[0] !== 1'b0 || data_o !== 16'hD001) begin fails++; $display("FAIL d_stall rdy=%b data=%h want 0/d001", ready_o[0], data_o); end
    cyc;
    ready_i = 1'b1;
    #1;
    tests++; if (ready_o[0] !== 1'b0) begin fails++; $display("FAIL d_rdy_indep got=%b want=0", ready_o[0]); end
    cyc; #1;
    tests++; if (ready_o[0] !== 1'b1 || data_o !== 16'hD002) begin fails++; $display("FAIL d_after_pop rdy=%b data=%h want 1/d002", ready_o[0], data_o); end
    cyc;
    v_i = 2'b00;
    #1;
    tests++; if (v_o !== 1'b1 || data_o !== 16'hD003) begin fails++; $display("FAIL d_third v_o=%b data=%h want 1/d003", v_o, data_o); end
    cyc; #1;
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL d_done v_o=%b want=0", v_o); end
  endtask

  task automatic test_case_e_three;
    rdy3_i = 1'b1;
    for (int j = 0; j < 5; j++) begin
      cyc;
      v3 = (j < 4) ? 3'b100 : 3'b000;
      d3 = {16'(16'hE200 + j), 16'h0000, 16'h0000};
      #1;
      if (j >= 1) begin
        tests++; if (v3_o !== 1'b1 || d3_o !== 16'(16'hE200 + j - 1)) begin fails++; $display("FAIL e_req2_%0d v_o=%b data=%h want 1/%h", j, v3_o, d3_o, 16'(16'hE200 + j - 1)); end
      end
    end
    cyc;
    rdy3_i = 1'b0; v3 = 3'b111; d3 = {16'h0E22, 16'h0E11, 16'h0E00};
    #1;
    tests++; if (v3_o !== 1'b0) begin fails++; $display("FAIL e_idle v_o=%b want=0", v3_o); end
    cyc;
    v3 = 3'b000; rdy3_i = 1'b1;
    #1;
    tests++; if (d3_o !== 16'h0E00) begin fails++; $display("FAIL e_order0 data=%h want 0e00", d3_o); end
    cyc; #1;
    tests++; if (d3_o !== 16'h0E11) begin fails++; $display("FAIL e_order1 data=%h want 0e11", d3_o); end
    cyc; #1;
    tests++; if (d3_o !== 16'h0E22) begin fails++; $display("FAIL e_order2 data=%h want 0e22", d3_o); end
    cyc; #1;
    tests++; if (v3_o !== 1'b0) begin fails++; $display("FAIL e_done v_o=%b want=0", v3_o); end
  endtask

  task automatic test_case_f_reset_lock;
    cyc;
    ready_i = 1'b0; v_i = 2'b11; data_i = {16'hF1A0, 16'hF0A0};
    #1;
    cyc;
    data_i = {16'hF1B0, 16'hF0B0};
    #1;
    tests++; if (v_o !== 1'b1) begin fails++; $display("FAIL f_valid v_o=%b want=1", v_o); end
    cyc;
    v_i = 2'b00;
    #1;
    tests++; if (ready_o !== 2'b00) begin fails++; $display("FAIL f_both_full ready_o=%b want=00", ready_o); end
    cyc;
    reset_i = 1'b1;
    #1;
    tests++; if (v_o !== 1'b0 || ready_o !== 2'b00) begin fails++; $display("FAIL f_in_reset v_o=%b ready_o=%b want 0/00", v_o, ready_o); end
    cyc;
    reset_i = 1'b0; ready_i = 1'b1;
    #1;
    tests++; if (v_o !== 1'b0 || ready_o !== 2'b11) begin fails++; $display("FAIL f_after_reset v_o=%b ready_o=%b want 0/11", v_o, ready_o); end
    for (int k = 0; k < 3; k++) begin
      cyc; #1;
      tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL f_stale%0d v_o=%b data=%h want v_o=0", k, v_o, data_o); end
    end
    cyc;
    v_i = 2'b10; data_i = {16'h5A5A, 16'h0000};
    #1;
    cyc;
    v_i = 2'b00;
    #1;
    tests++; if (v_o !== 1'b1 || data_o !== 16'h5A5A) begin fails++; $display("FAIL f_fresh v_o=%b data=%h want 1/5a5a", v_o, data_o); end
    cyc; #1;
    tests++; if (v_o !== 1'b0) begin fails++; $display("FAIL f_done v_o=%b want=0", v_o); end
  endtask

  initial begin
    test_reset;
    test_case_a;
    test_case_c_lock;
    test_back_to_back;
    test_case_d_full;
    test_case_e_three;
    test_case_f_reset_lock;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout after %0d tests", tests);
    $fatal(1, "watchdog");
  end

endmodule
